// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the arbitrated ALU block: FSM states, opcode map and datapath width.
package alu_ctrl_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 16-bit ALU. Shift amount is num_2_i[3:0]; opcodes with bit 3 set
// return zero and flag err_o.
module alu_arbiter_alu
  import alu_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] num_1_i,
  input  logic [DATA_W-1:0] num_2_i,
  input  logic [3:0]        opcode_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              zero_o,
  output logic              err_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, num_1_i} + {1'b0, num_2_i};
  assign diff = {1'b0, num_1_i} - {1'b0, num_2_i};

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (opcode_i)
      OP_ADD: {carry_o, result_o} = sum;
      OP_SUB: {carry_o, result_o} = diff;
      OP_AND: result_o = num_1_i & num_2_i;
      OP_OR:  result_o = num_1_i | num_2_i;
      OP_XOR: result_o = num_1_i ^ num_2_i;
      OP_NOT: result_o = ~num_1_i;
      OP_SHL: result_o = num_1_i << num_2_i[3:0];
      OP_SHR: result_o = num_1_i >> num_2_i[3:0];
      default: begin
        result_o = '0;
        carry_o  = 1'b0;
      end
    endcase
  end

  assign zero_o = (result_o == '0);
  assign err_o  = opcode_i[3];

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU: grant in IDLE,
// evaluate for one cycle in EXEC, hold the response in RESP until accepted.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter logic RR_START = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_num_1,
  input  logic [DATA_W-1:0] req0_num_2,
  input  logic [3:0]        req0_opcode,
  input  logic [DATA_W-1:0] req1_num_1,
  input  logic [DATA_W-1:0] req1_num_2,
  input  logic [3:0]        req1_opcode,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_carry,
  output logic              resp_err,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              grant_id;
  logic              hs;

  logic [DATA_W-1:0] a_q, b_q;
  logic [3:0]        op_q;
  logic              id_q;

  logic [DATA_W-1:0] res_q;
  logic              zero_q, carry_q, err_q, rid_q;

  logic [DATA_W-1:0] alu_res;
  logic              alu_carry, alu_zero, alu_err;

  // Pointer only breaks ties; a lone requester always wins.
  assign grant_id = (&req_valid) ? ptr_q : req_valid[1];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    req_ready = '0;
    hs        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && (|req_valid)) begin
          req_ready = grant_id ? 2'b10 : 2'b01;
          hs        = 1'b1;
          ptr_d     = ~grant_id;
          state_d   = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= RR_START;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (hs) begin
        id_q <= grant_id;
        a_q  <= grant_id ? req1_num_1  : req0_num_1;
        b_q  <= grant_id ? req1_num_2  : req0_num_2;
        op_q <= grant_id ? req1_opcode : req0_opcode;
      end
      if (state_q == EXEC) begin
        res_q   <= alu_res;
        zero_q  <= alu_zero;
        // ALU reports borrow on SUB; only the adder carry is architecturally visible.
        carry_q <= alu_carry & (op_q == OP_ADD);
        err_q   <= alu_err;
        rid_q   <= id_q;
      end
    end
  end

  alu_arbiter_alu u_alu (
    .num_1_i  (a_q),
    .num_2_i  (b_q),
    .opcode_i (op_q),
    .result_o (alu_res),
    .carry_o  (alu_carry),
    .zero_o   (alu_zero),
    .err_o    (alu_err)
  );

  assign resp_valid  = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign resp_id     = rid_q;
  assign resp_result = res_q;
  assign resp_zero   = zero_q;
  assign resp_carry  = carry_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, corner sequences,
// and randomized traffic checked against a transaction-level model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req0_num_1, req0_num_2, req1_num_1, req1_num_2;
  logic [3:0]  req0_opcode, req1_opcode;
  logic        resp_valid, resp_ready, resp_id;
  logic [15:0] resp_result;
  logic        resp_zero, resp_carry, resp_err, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_START(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_num_1  (req0_num_1),
    .req0_num_2  (req0_num_2),
    .req0_opcode (req0_opcode),
    .req1_num_1  (req1_num_1),
    .req1_num_2  (req1_num_2),
    .req1_opcode (req1_opcode),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .resp_carry  (resp_carry),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        e;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {err, carry, zero, result} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    int unsigned ua, ub, s;
    logic [15:0] r;
    logic        c;
    ua = a;
    ub = b;
    c  = 1'b0;
    r  = '0;
    case (op)
      4'd0: begin s = ua + ub; r = s[15:0]; c = (s > 32'd65535); end
      4'd1: begin s = ua - ub; r = s[15:0]; end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin s = ua * (32'd1 << (ub % 16)); r = s[15:0]; end
      4'd7: begin s = ua / (32'd1 << (ub % 16)); r = s[15:0]; end
      default: r = '0;
    endcase
    return {(op >= 4'd8), c, (r == 16'h0000), r};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    req_valid  = 2'b11;
    resp_ready = 1'b0;
    #1;
    chk("ready_in_rst_a", req_ready, 2'b00);
    @(negedge clk);
    #1;
    chk("ready_in_rst_b", req_ready, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_result", resp_result, 16'h0000);
    chk("rst_flags", {resp_zero, resp_carry, resp_err, resp_id}, 4'b0000);
    rst       = 1'b0;
    req_valid = 2'b00;
  endtask

  // Issue one operation with valid pattern v, expecting requester gid to win,
  // then hold the response for 'hold' cycles while driving hold_valid.
  task automatic do_op(input string nm, input logic [1:0] v, input logic gid,
                       input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                       input logic [18:0] exp, input int hold, input logic [1:0] hold_valid);
    @(negedge clk);
    req0_num_1  = $urandom; req0_num_2 = $urandom; req0_opcode = 4'($urandom);
    req1_num_1  = $urandom; req1_num_2 = $urandom; req1_opcode = 4'($urandom);
    if (gid) begin
      req1_num_1 = a; req1_num_2 = b; req1_opcode = op;
    end else begin
      req0_num_1 = a; req0_num_2 = b; req0_opcode = op;
    end
    req_valid  = v;
    resp_ready = 1'b0;
    #1;
    chk({nm, "_grant"}, req_ready, gid ? 2'b10 : 2'b01);
    @(negedge clk);
    req_valid  = 2'b00;
    req0_num_1 = ~a; req0_num_2 = ~b; req0_opcode = ~op;
    req1_num_1 = ~a; req1_num_2 = ~b; req1_opcode = ~op;
    chk({nm, "_exec_valid"}, resp_valid, 1'b0);
    chk({nm, "_exec_busy"}, busy, 1'b1);
    @(negedge clk);
    chk({nm, "_valid"}, resp_valid, 1'b1);
    chk({nm, "_id"}, resp_id, gid);
    chk({nm, "_result"}, resp_result, exp[15:0]);
    chk({nm, "_zce"}, {resp_zero, resp_carry, resp_err}, {exp[16], exp[17], exp[18]});
    for (int i = 0; i < hold; i++) begin
      req_valid = hold_valid;
      #1;
      chk({nm, "_hold_ready"}, req_ready, 2'b00);
      chk({nm, "_hold_state"}, {resp_valid, busy}, 2'b11);
      chk({nm, "_hold_out"}, {resp_id, resp_zero, resp_carry, resp_err, resp_result},
          {gid, exp[16], exp[17], exp[18], exp[15:0]});
      @(negedge clk);
      req_valid = 2'b00;
    end
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, "_idle_valid"}, resp_valid, 1'b0);
    chk({nm, "_idle_busy"}, busy, 1'b0);
    chk({nm, "_idle_keep"}, resp_result, exp[15:0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0] grants [4];
    int         gcyc [4];
    int         g;
    logic       mptr;
    logic [1:0] v;
    logic       gid;
    logic [15:0] a, b;
    logic [3:0]  op;

    vecs[0]  = '{1'b0, 16'hFFFF, 16'h0001, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 16'h0005, 16'h0007, 4'h1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 16'h1234, 16'h5678, 4'hA, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 16'h1234, 16'h1111, 4'h0, 16'h2345, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'hF0F0, 16'hFF00, 4'h2, 16'hF000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 16'h0F00, 16'h00F0, 4'h3, 16'h0FF0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'hAAAA, 16'hAAAA, 4'h4, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'h00FF, 16'h1234, 4'h5, 16'hFF00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 16'h0001, 16'h0004, 4'h6, 16'h0010, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'h8000, 16'h000F, 4'h7, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 16'h8000, 16'h8000, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 16'h0001, 16'h0001, 4'hF, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 16'h0000, 16'h0001, 4'h1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
    req0_num_1 = '0; req0_num_2 = '0; req0_opcode = '0;
    req1_num_1 = '0; req1_num_2 = '0; req1_opcode = '0;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].id ? 2'b10 : 2'b01, vecs[i].id,
            vecs[i].a, vecs[i].b, vecs[i].op,
            {vecs[i].e, vecs[i].c, vecs[i].z, vecs[i].res}, 0, 2'b00);
    end

    // Round-robin with both requesters continuously valid.
    do_reset();
    @(negedge clk);
    req_valid  = 2'b11;
    resp_ready = 1'b1;
    g = 0;
    for (int cyc = 0; cyc < 30 && g < 4; cyc++) begin
      #1;
      if (req_ready != 2'b00) begin
        grants[g] = req_ready;
        gcyc[g]   = cyc;
        g++;
      end
      @(negedge clk);
    end
    chk("rr_count", g, 4);
    for (int i = 0; i < g; i++) begin
      chk($sformatf("rr_grant%0d", i), grants[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) chk($sformatf("rr_spacing%0d", i), gcyc[i] - gcyc[i-1], 3);
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    resp_ready = 1'b0;

    // Back-pressure: response held five cycles while both requesters wait.
    do_op("sub_hold", 2'b10, 1'b1, 16'h0005, 16'h0007, 4'h1,
          {1'b0, 1'b0, 1'b0, 16'hFFFE}, 5, 2'b11);

    // One-cycle pulse from requester 1 during RESP must not be captured.
    do_op("pulse", 2'b01, 1'b0, 16'h0003, 16'h0004, 4'h0,
          {1'b0, 1'b0, 1'b0, 16'h0007}, 1, 2'b10);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("pulse_no_resp", {resp_valid, busy}, 2'b00);
    end

    // Reset while in EXEC discards the operation; next grant goes to RR_START.
    @(negedge clk);
    req0_num_1 = 16'hFFFF; req0_num_2 = 16'h0001; req0_opcode = 4'h0;
    req_valid  = 2'b01;
    #1;
    chk("kill_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    chk("kill_in_exec", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("kill_after_rst", {resp_valid, busy, resp_carry, resp_zero}, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("kill_no_resp", resp_valid, 1'b0);
    end
    do_op("kill_next", 2'b11, 1'b0, 16'h0102, 16'h0304, 4'h0,
          model(4'h0, 16'h0102, 16'h0304), 0, 2'b00);

    // Randomized traffic against the transaction-level model.
    do_reset();
    mptr = 1'b0;
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("rnd_idle_ready", {req_ready, resp_valid}, 3'b000);
      end
      v    = 2'($urandom_range(1, 3));
      gid  = (v == 2'b11) ? mptr : (v == 2'b10);
      mptr = ~gid;
      a    = 16'($urandom);
      b    = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      op   = 4'($urandom_range(0, 15));
      do_op($sformatf("rnd%0d", it), v, gid, a, b, op, model(op, a, b),
            $urandom_range(0, 3), 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
